// File: rtl/page_arb_pkg.sv
// Shared types and constants for the two-master paged memory arbiter.
package page_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_CMD   = 2'd2,
    RD_DATA  = 2'd3
  } arb_state_t;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

endpackage

// File: rtl/avmm_if.sv
// Avalon-MM bundle with burst support; master drives commands, slave responds.
interface avmm_if #(
  parameter int AW = 16,
  parameter int DW = 64,
  parameter int BW = 1
);
  logic [AW-1:0]   address;
  logic [BW-1:0]   burstcount;
  logic [DW/8-1:0] byteenable;
  logic [DW-1:0]   writedata;
  logic [DW-1:0]   readdata;
  logic            read;
  logic            write;
  logic            waitrequest;
  logic            readdatavalid;

  modport master (
    output address, burstcount, byteenable, writedata, read, write,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, burstcount, byteenable, writedata, read, write,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/page_arbiter_rr.sv
// Two-input round-robin pick. A lone requester always wins; on contention the
// master that did not own the previous burst wins.
module rr_arbiter2
  import page_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] grant
);

  // Combinational one-hot pick from the request pair and the last owner.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_owner == OWNER_M0) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/page_arbiter.sv
// Burst-granular round-robin arbiter letting two AVMM masters share one paged
// memory controller. The winner's page is latched at grant and held for the
// whole burst; commands are forwarded combinationally from the owner.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no owner; arbitrate pending requests (1 cycle, nothing forwarded)
// WR_BURST | owner's write beats forwarded, counted on acceptance
// RD_CMD   | owner's read command forwarded until accepted
// RD_DATA  | read command masked; count returning readdatavalid beats
module page_arbiter
  import page_arb_pkg::*;
#(
  parameter int AW         = 16,
  parameter int DW         = 64,
  parameter int MAX_BURST  = 1,
  parameter int PAGE_COUNT = 4,
  parameter int PCW        = $clog2(PAGE_COUNT)
) (
  input  logic           clock,
  input  logic           reset,
  avmm_if.slave          m0,
  avmm_if.slave          m1,
  input  logic [PCW-1:0] m0_page,
  input  logic [PCW-1:0] m1_page,
  avmm_if.master         mem,
  output logic [PCW-1:0] page_number,
  output logic [1:0]     grant,
  output logic           busy
);

  localparam int BCW = $clog2(MAX_BURST + 1);

  arb_state_t      state;
  logic            owner;
  logic            last_owner;
  logic [BCW-1:0]  beat_cnt;
  logic [BCW-1:0]  burst_q;
  logic [AW-1:0]   addr_q;

  logic [1:0]      req;
  logic [1:0]      pick;
  logic            win_write;
  logic [BCW-1:0]  win_burst_raw;
  logic [BCW-1:0]  win_burst;
  logic [PCW-1:0]  win_page;
  logic [AW-1:0]   win_addr;

  logic            granted;
  logic            own_m0;
  logic            own_m1;
  logic            own_read;
  logic            own_write;
  logic [DW-1:0]   own_wdata;
  logic [DW/8-1:0] own_be;
  logic            last_beat;

  assign req = {m1.read | m1.write, m0.read | m0.write};

  rr_arbiter2 u_rr (
    .req        (req),
    .last_owner (last_owner),
    .grant      (pick)
  );

  // Winner's command fields, captured only on the IDLE grant cycle.
  always_comb begin
    win_write     = pick[1] ? m1.write      : m0.write;
    win_burst_raw = pick[1] ? m1.burstcount : m0.burstcount;
    win_page      = pick[1] ? m1_page       : m0_page;
    win_addr      = pick[1] ? m1.address    : m0.address;
    win_burst     = (win_burst_raw == '0) ? BCW'(1) : win_burst_raw;
  end

  // Owner-side selection and burst-end detection.
  always_comb begin
    granted   = (state != IDLE);
    own_m0    = granted && (owner == OWNER_M0);
    own_m1    = granted && (owner == OWNER_M1);
    own_read  = (owner == OWNER_M1) ? m1.read       : m0.read;
    own_write = (owner == OWNER_M1) ? m1.write      : m0.write;
    own_wdata = (owner == OWNER_M1) ? m1.writedata  : m0.writedata;
    own_be    = (owner == OWNER_M1) ? m1.byteenable : m0.byteenable;
    last_beat = (beat_cnt == burst_q - BCW'(1));
  end

  // Memory side: command strobes only in the states that own them.
  assign mem.address    = addr_q;
  assign mem.burstcount = burst_q;
  assign mem.byteenable = own_be;
  assign mem.writedata  = own_wdata;
  assign mem.write      = (state == WR_BURST) && own_write;
  assign mem.read       = (state == RD_CMD) && own_read;

  // Master side: the non-owner is stalled and sees no read data.
  assign m0.waitrequest   = own_m0 ? mem.waitrequest : 1'b1;
  assign m0.readdatavalid = own_m0 && mem.readdatavalid;
  assign m0.readdata      = own_m0 ? mem.readdata : '0;
  assign m1.waitrequest   = own_m1 ? mem.waitrequest : 1'b1;
  assign m1.readdatavalid = own_m1 && mem.readdatavalid;
  assign m1.readdata      = own_m1 ? mem.readdata : '0;

  // Arbitration and burst sequencing FSM with registered grant/page/busy.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= 2'b00;
      busy        <= 1'b0;
      page_number <= '0;
      beat_cnt    <= '0;
      burst_q     <= '0;
      addr_q      <= '0;
      owner       <= OWNER_M0;
      last_owner  <= OWNER_M1;
    end else begin
      case (state)
        IDLE: begin
          if (pick != 2'b00) begin
            grant       <= pick;
            busy        <= 1'b1;
            owner       <= pick[1] ? OWNER_M1 : OWNER_M0;
            page_number <= win_page;
            burst_q     <= win_burst;
            addr_q      <= win_addr;
            beat_cnt    <= '0;
            state       <= win_write ? WR_BURST : RD_CMD;
          end
        end
        WR_BURST: begin
          if (own_write && !mem.waitrequest) begin
            if (last_beat) begin
              state      <= IDLE;
              grant      <= 2'b00;
              busy       <= 1'b0;
              last_owner <= owner;
              beat_cnt   <= '0;
            end else begin
              beat_cnt <= beat_cnt + BCW'(1);
            end
          end
        end
        RD_CMD: begin
          if (own_read && !mem.waitrequest) begin
            state <= RD_DATA;
            // A beat returning in the acceptance cycle still counts.
            if (mem.readdatavalid) begin
              if (last_beat) begin
                state      <= IDLE;
                grant      <= 2'b00;
                busy       <= 1'b0;
                last_owner <= owner;
                beat_cnt   <= '0;
              end else begin
                beat_cnt <= beat_cnt + BCW'(1);
              end
            end
          end
        end
        RD_DATA: begin
          if (mem.readdatavalid) begin
            if (last_beat) begin
              state      <= IDLE;
              grant      <= 2'b00;
              busy       <= 1'b0;
              last_owner <= owner;
              beat_cnt   <= '0;
            end else begin
              beat_cnt <= beat_cnt + BCW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_page_arbiter.sv
// Scoreboard bench for page_arbiter: masters push expected grants, write beats
// and read data; a memory model and monitors pop and compare as they appear.
module tb_page_arbiter;
  import page_arb_pkg::*;

  localparam int AW         = 16;
  localparam int DW         = 64;
  localparam int MAX_BURST  = 4;
  localparam int PAGE_COUNT = 4;
  localparam int PCW        = 2;
  localparam int BCW        = 3;

  typedef struct {
    logic [PCW-1:0] page;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
    logic [BCW-1:0] bc;
  } wr_exp_t;

  typedef struct {
    logic [1:0]     gnt;
    logic [PCW-1:0] page;
  } gnt_exp_t;

  logic clock;
  logic reset;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  avmm_if #(.AW(AW), .DW(DW), .BW(BCW)) if_m0 ();
  avmm_if #(.AW(AW), .DW(DW), .BW(BCW)) if_m1 ();
  avmm_if #(.AW(AW), .DW(DW), .BW(BCW)) if_mem ();

  logic [1:0]     m_read, m_write, m_wait, m_rdv;
  logic [AW-1:0]  m_addr  [2];
  logic [BCW-1:0] m_bc    [2];
  logic [DW-1:0]  m_wdata [2];
  logic [DW-1:0]  m_rdata [2];
  logic [PCW-1:0] m_page  [2];

  logic [PCW-1:0] page_number;
  logic [1:0]     grant;
  logic           busy;

  logic           mem_wait, mem_rdv;
  logic [DW-1:0]  mem_rdata;
  bit             inject_rdv;

  wr_exp_t        exp_wr [2][$];
  logic [DW-1:0]  exp_rd [2][$];
  gnt_exp_t       exp_gnt[$];
  logic [DW-1:0]  pend[$];

  int checks = 0;
  int errors = 0;

  assign if_m0.read       = m_read[0];
  assign if_m0.write      = m_write[0];
  assign if_m0.address    = m_addr[0];
  assign if_m0.burstcount = m_bc[0];
  assign if_m0.writedata  = m_wdata[0];
  assign if_m0.byteenable = 8'hFF;
  assign if_m1.read       = m_read[1];
  assign if_m1.write      = m_write[1];
  assign if_m1.address    = m_addr[1];
  assign if_m1.burstcount = m_bc[1];
  assign if_m1.writedata  = m_wdata[1];
  assign if_m1.byteenable = 8'hFF;
  assign m_wait[0]  = if_m0.waitrequest;
  assign m_wait[1]  = if_m1.waitrequest;
  assign m_rdv[0]   = if_m0.readdatavalid;
  assign m_rdv[1]   = if_m1.readdatavalid;
  assign m_rdata[0] = if_m0.readdata;
  assign m_rdata[1] = if_m1.readdata;

  assign if_mem.waitrequest   = mem_wait;
  assign if_mem.readdatavalid = mem_rdv;
  assign if_mem.readdata      = mem_rdata;

  page_arbiter #(
    .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST), .PAGE_COUNT(PAGE_COUNT), .PCW(PCW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .m0          (if_m0),
    .m1          (if_m1),
    .m0_page     (m_page[0]),
    .m1_page     (m_page[1]),
    .mem         (if_mem),
    .page_number (page_number),
    .grant       (grant),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd_pat(input logic [PCW-1:0] p, input logic [AW-1:0] a,
                                           input int b);
    return {8'(p), a, 8'(b), 32'h5A5A_C3C3};
  endfunction

  // Memory model: random waitrequest, read data returned with random gaps.
  initial begin : mem_model
    int id;
    wr_exp_t e;
    mem_wait  = 1'b1;
    mem_rdv   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      #1;
      if (reset) begin
        pend.delete();
        mem_wait  = 1'b1;
        mem_rdv   = 1'b0;
        mem_rdata = '0;
      end else begin
        mem_wait = ($urandom_range(0, 3) == 0);
        if (inject_rdv) begin
          mem_rdv   = 1'b1;
          mem_rdata = '1;
        end else if (pend.size() > 0 && $urandom_range(0, 3) != 0) begin
          mem_rdv   = 1'b1;
          mem_rdata = pend.pop_front();
        end else begin
          mem_rdv   = 1'b0;
          mem_rdata = '0;
        end
      end
      #1;
      if (!reset) begin
        if (if_mem.write && !mem_wait) begin
          chk("wr_has_owner", grant != 2'b00, 1);
          id = grant[1] ? 1 : 0;
          chk("wr_beat_expected", exp_wr[id].size() > 0, 1);
          if (exp_wr[id].size() > 0) begin
            e = exp_wr[id].pop_front();
            chk($sformatf("wr%0d_page", id), page_number, e.page);
            chk($sformatf("wr%0d_addr", id), if_mem.address, e.addr);
            chk($sformatf("wr%0d_data", id), if_mem.writedata, e.data);
            chk($sformatf("wr%0d_bc", id), if_mem.burstcount, e.bc);
            chk($sformatf("wr%0d_be", id), if_mem.byteenable, 8'hFF);
          end
        end
        if (if_mem.read && !mem_wait) begin
          for (int b = 0; b < int'(if_mem.burstcount); b++)
            pend.push_back(rd_pat(page_number, if_mem.address, b));
        end
      end
    end
  end

  // Read-data monitor: each master's returned beats against its expectations.
  initial begin : rd_monitor
    logic [DW-1:0] e;
    forever begin
      @(negedge clock);
      #2;
      for (int i = 0; i < 2; i++) begin
        if (m_rdv[i]) begin
          chk($sformatf("rd%0d_beat_expected", i), exp_rd[i].size() > 0, 1);
          if (exp_rd[i].size() > 0) begin
            e = exp_rd[i].pop_front();
            chk($sformatf("rd%0d_data", i), m_rdata[i], e);
          end
        end
      end
    end
  end

  // Grant monitor: each new grant in order, with its latched page.
  initial begin : gnt_monitor
    logic [1:0] prev;
    gnt_exp_t   ge;
    prev = 2'b00;
    forever begin
      @(negedge clock);
      #2;
      if (grant !== prev) begin
        chk("busy_vs_grant", busy, grant != 2'b00);
        if (grant != 2'b00) begin
          chk("grant_expected", exp_gnt.size() > 0, 1);
          if (exp_gnt.size() > 0) begin
            ge = exp_gnt.pop_front();
            chk("grant_order", grant, ge.gnt);
            chk("grant_page", page_number, ge.page);
          end
        end
        prev = grant;
      end
    end
  end

  task automatic do_write(input int id, input logic [PCW-1:0] page, input logic [AW-1:0] addr,
                          input logic [BCW-1:0] bc, input logic [DW-1:0] base,
                          input int stall_after, input int stall_len, input bit toggle);
    int nb;
    int b;
    int guard;
    bit acc;
    nb = (bc == 0) ? 1 : int'(bc);
    for (int i = 0; i < nb; i++)
      exp_wr[id].push_back('{page, addr, base + DW'(i), BCW'(nb)});
    m_page[id]  = page;
    m_addr[id]  = addr;
    m_bc[id]    = bc;
    m_wdata[id] = base;
    m_write[id] = 1'b1;
    b     = 0;
    guard = 0;
    while (b < nb && guard < 100) begin
      #2;
      acc = m_write[id] && !m_wait[id];
      @(negedge clock);
      guard++;
      if (acc) begin
        b++;
        m_wdata[id] = base + DW'(b);
        if (b == stall_after && b < nb) begin
          m_write[id] = 1'b0;
          if (toggle) m_page[id] = ~m_page[id];
          repeat (stall_len) @(negedge clock);
          m_write[id] = 1'b1;
        end
      end
    end
    m_write[id] = 1'b0;
    chk($sformatf("wr%0d_timeout", id), guard >= 100, 0);
  endtask

  task automatic do_read(input int id, input logic [PCW-1:0] page, input logic [AW-1:0] addr,
                         input logic [BCW-1:0] bc);
    int nb;
    int guard;
    bit acc;
    nb = (bc == 0) ? 1 : int'(bc);
    for (int i = 0; i < nb; i++) exp_rd[id].push_back(rd_pat(page, addr, i));
    m_page[id] = page;
    m_addr[id] = addr;
    m_bc[id]   = bc;
    m_read[id] = 1'b1;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 100) begin
      #2;
      acc = m_read[id] && !m_wait[id];
      @(negedge clock);
      guard++;
    end
    m_read[id] = 1'b0;
    chk($sformatf("rd%0d_cmd_timeout", id), guard >= 100, 0);
  endtask

  task automatic wait_rd_empty(input string tag);
    int g;
    g = 0;
    while ((exp_rd[0].size() + exp_rd[1].size()) != 0 && g < 200) begin
      @(negedge clock);
      g++;
    end
    chk(tag, g >= 200, 0);
  endtask

  initial begin : stimulus
    int g;
    int left;
    m_read     = '0;
    m_write    = '0;
    inject_rdv = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_addr[i]  = '0;
      m_bc[i]    = '0;
      m_wdata[i] = '0;
      m_page[i]  = '0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clock);
    #2;
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_page", page_number, 0);
    chk("rst_mem_read", if_mem.read, 0);
    chk("rst_mem_write", if_mem.write, 0);
    chk("rst_m0_wait", m_wait[0], 1);
    chk("rst_m1_wait", m_wait[1], 1);
    chk("rst_rdv", m_rdv, 2'b00);
    @(negedge clock);
    reset = 1'b0;

    // Single-beat write from m0.
    @(negedge clock);
    exp_gnt.push_back('{2'b01, 2'd2});
    fork
      do_write(0, 2'd2, 16'h0010, 3'd1, 64'hA5A5, 0, 0, 1'b0);
      begin
        @(negedge clock);
        #3;
        chk("t1_grant_latency", grant, 2'b01);
        chk("t1_page", page_number, 2);
      end
    join
    #3;
    chk("t1_busy_release", busy, 0);
    chk("t1_grant_release", grant, 2'b00);

    // Fresh reset, then simultaneous reads: m0 wins the first tie.
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    exp_gnt.push_back('{2'b01, 2'd1});
    exp_gnt.push_back('{2'b10, 2'd3});
    fork
      do_read(0, 2'd1, 16'h0100, 3'd2);
      do_read(1, 2'd3, 16'h0200, 3'd3);
    join
    wait_rd_empty("t2_rd_timeout");

    // Four-beat m1 write with a stall and a page change mid-burst.
    @(negedge clock);
    exp_gnt.push_back('{2'b10, 2'd0});
    do_write(1, 2'd0, 16'h0300, 3'd4, 64'h3000, 2, 2, 1'b1);
    #3;
    chk("t3_busy_release", busy, 0);
    chk("t3_wr_left", exp_wr[1].size(), 0);

    // Contention: m0 keeps requesting, m1 once -> m0, m1, m0.
    @(negedge clock);
    exp_gnt.push_back('{2'b01, 2'd1});
    exp_gnt.push_back('{2'b10, 2'd3});
    exp_gnt.push_back('{2'b01, 2'd2});
    fork
      begin
        do_write(0, 2'd1, 16'h0400, 3'd2, 64'h4000, 0, 0, 1'b0);
        do_write(0, 2'd2, 16'h0410, 3'd1, 64'h4100, 0, 0, 1'b0);
      end
      do_read(1, 2'd3, 16'h0500, 3'd2);
    join
    wait_rd_empty("t4_rd_timeout");

    // Reset after the first beat of a four-beat read.
    @(negedge clock);
    exp_gnt.push_back('{2'b01, 2'd2});
    do_read(0, 2'd2, 16'h0600, 3'd4);
    g = 0;
    while (exp_rd[0].size() == 4 && g < 100) begin
      @(negedge clock);
      g++;
    end
    chk("t5_first_beat_timeout", g >= 100, 0);
    reset = 1'b1;
    left  = exp_rd[0].size();
    chk("t5_beats_left", left, 3);
    @(negedge clock);
    reset      = 1'b0;
    inject_rdv = 1'b1;
    exp_rd[0].delete();
    #2;
    chk("t5_grant", grant, 2'b00);
    chk("t5_busy", busy, 0);
    chk("t5_mem_read", if_mem.read, 0);
    chk("t5_page", page_number, 0);
    chk("t5_rdv_blocked", m_rdv, 2'b00);
    @(negedge clock);
    inject_rdv = 1'b0;
    exp_gnt.push_back('{2'b10, 2'd1});
    do_read(1, 2'd1, 16'h0700, 3'd2);
    wait_rd_empty("t5_rd_timeout");

    // Zero burstcount write behaves as one beat.
    @(negedge clock);
    exp_gnt.push_back('{2'b10, 2'd3});
    do_write(1, 2'd3, 16'h0800, 3'd0, 64'h8000, 0, 0, 1'b0);
    #3;
    chk("t6_busy_release", busy, 0);
    chk("t6_grant_release", grant, 2'b00);

    repeat (3) @(negedge clock);
    chk("end_gnt_left", exp_gnt.size(), 0);
    chk("end_wr0_left", exp_wr[0].size(), 0);
    chk("end_wr1_left", exp_wr[1].size(), 0);
    chk("end_rd0_left", exp_rd[0].size(), 0);
    chk("end_rd1_left", exp_rd[1].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
